// File: rtl/riscv_wb_pkg.sv
// Shared definitions for the register-file writeback slice: default widths
// and the write-port bundle layout used by the writeback logic.
package riscv_wb_pkg;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_LSU_DEPTH  = 2;

  // One register-file write port at the default widths.
  typedef struct packed {
    logic                     we;
    logic [WB_ADDR_WIDTH-1:0] waddr;
    logic [WB_DATA_WIDTH-1:0] wdata;
  } wb_port_t;

  // Even parity over a default-width write address, for consumers that
  // carry a protection bit alongside the port.
  function automatic logic waddr_parity(input logic [WB_ADDR_WIDTH-1:0] addr);
    return ^addr;
  endfunction

endpackage : riscv_wb_pkg

// File: rtl/riscv_wb_tag_fifo.sv
// Synchronous FIFO of destination-register tags for outstanding loads.
// Push and pop in the same cycle are both honoured when full (count holds);
// a pop while empty is ignored.
module riscv_wb_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Advance a pointer with wrap-around at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Qualify push/pop: a full FIFO accepts a push only alongside a pop.
  always_comb begin
    pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);
  end

  // Tag storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});

endmodule : riscv_wb_tag_fifo

// File: rtl/riscv_rf_writeback.sv
// Write side of the flip-flop register file. Port A carries registered ALU
// results, port B carries load data tagged in issue order. A pending-write
// scoreboard stalls issue on RAW/WAW hazards against outstanding loads.
module riscv_rf_writeback
  import riscv_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int LSU_DEPTH  = WB_LSU_DEPTH,
  parameter int NUM_WORDS  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  input  logic [2:0]            rsrc_used_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic                  rd_valid_i,
  input  logic                  is_load_i,
  input  logic                  alu_we_i,
  input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
  input  logic [DATA_WIDTH-1:0] alu_wdata_i,
  input  logic                  lsu_rvalid_i,
  input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o,
  output logic [NUM_WORDS-1:0]  pending_o,
  output logic                  lsu_err_o
);

  localparam int CNT_W = $clog2(LSU_DEPTH + 1);

  // Same layout as wb_port_t, sized by this instance's parameters.
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } port_t;

  localparam logic [ADDR_WIDTH-1:0] X0 = {ADDR_WIDTH{1'b0}};

  port_t                 port_a_r;
  port_t                 port_b_r;
  logic [NUM_WORDS-1:0]  pending_r;
  logic [NUM_WORDS-1:0]  pending_nxt_s;
  logic                  lsu_err_r;

  logic                  hazard_s;
  logic                  issue_fire_s;
  logic                  load_push_s;
  logic [ADDR_WIDTH-1:0] push_tag_s;
  logic                  rsp_pop_s;
  logic                  rsp_orphan_s;

  logic [ADDR_WIDTH-1:0] fifo_head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [CNT_W-1:0]      fifo_count_s;

  // Tags of outstanding loads, oldest at the head; responses arrive in order.
  riscv_wb_tag_fifo #(
    .DEPTH (LSU_DEPTH),
    .WIDTH (ADDR_WIDTH),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (load_push_s),
    .push_data (push_tag_s),
    .pop       (rsp_pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Hazard detection. Only loads are tracked (ALU RAW is forwarded in EX), and
  // a load still counts while its write sits on port B because the register
  // file only captures at the end of that cycle. The full check deliberately
  // ignores a same-cycle response so lsu_rvalid_i never reaches issue_ready_o.
  always_comb begin
    hazard_s = (rsrc_used_i[0] && pending_r[raddr_a_i]) ||
               (rsrc_used_i[1] && pending_r[raddr_b_i]) ||
               (rsrc_used_i[2] && pending_r[raddr_c_i]) ||
               (rd_valid_i && pending_r[rd_i])          ||
               (is_load_i && fifo_full_s);
  end

  // Issue handshake and FIFO control. Loads always push a tag; an untracked
  // destination is pushed as x0 so its response is dropped.
  always_comb begin
    issue_fire_s = issue_valid_i && !hazard_s;
    load_push_s  = issue_fire_s && is_load_i;
    if (rd_valid_i) begin
      push_tag_s = rd_i;
    end else begin
      push_tag_s = X0;
    end
    rsp_pop_s    = lsu_rvalid_i && (fifo_count_s != {CNT_W{1'b0}});
    rsp_orphan_s = lsu_rvalid_i && fifo_empty_s;
  end

  // Next scoreboard: clear the register being written on port B, then set a
  // newly issued load's destination so a same-register set wins. x0 never pends.
  always_comb begin
    pending_nxt_s = pending_r;
    if (port_b_r.we) begin
      pending_nxt_s[port_b_r.waddr] = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (load_push_s && rd_valid_i && (rd_i != X0)) begin
      pending_nxt_s[rd_i] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {NUM_WORDS{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Port A: register ALU results; writes to x0 are suppressed, address/data
  // hold their last written value between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_a_r <= '{we: 1'b0, waddr: X0, wdata: {DATA_WIDTH{1'b0}}};
    end else begin
      port_a_r.we <= alu_we_i && (alu_waddr_i != X0);
      if (alu_we_i) begin
        port_a_r.waddr <= alu_waddr_i;
        port_a_r.wdata <= alu_wdata_i;
      end else begin
        port_a_r.waddr <= port_a_r.waddr;
        port_a_r.wdata <= port_a_r.wdata;
      end
    end
  end

  // Port B: a response pops the head tag and writes the load data next cycle;
  // an x0 tag consumes the response without writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_b_r <= '{we: 1'b0, waddr: X0, wdata: {DATA_WIDTH{1'b0}}};
    end else begin
      port_b_r.we <= rsp_pop_s && (fifo_head_s != X0);
      if (rsp_pop_s && (fifo_head_s != X0)) begin
        port_b_r.waddr <= fifo_head_s;
        port_b_r.wdata <= lsu_rdata_i;
      end else begin
        port_b_r.waddr <= port_b_r.waddr;
        port_b_r.wdata <= port_b_r.wdata;
      end
    end
  end

  // Sticky flag for a response that had no outstanding load to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_err_r <= 1'b0;
    end else begin
      lsu_err_r <= lsu_err_r || rsp_orphan_s;
    end
  end

  assign issue_ready_o = !hazard_s;
  assign we_a_o        = port_a_r.we;
  assign waddr_a_o     = port_a_r.waddr;
  assign wdata_a_o     = port_a_r.wdata;
  assign we_b_o        = port_b_r.we;
  assign waddr_b_o     = port_b_r.waddr;
  assign wdata_b_o     = port_b_r.wdata;
  assign pending_o     = pending_r;
  assign lsu_err_o     = lsu_err_r;

endmodule : riscv_rf_writeback

// File: tb/tb_riscv_rf_writeback.sv
// Directed bench for riscv_rf_writeback, plus a direct look at the tag FIFO
// for the push-and-pop-at-full case the top level cannot produce.
module tb_riscv_rf_writeback;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid, issue_ready;
  logic [AW-1:0] raddr_a, raddr_b, raddr_c, rd, alu_waddr, waddr_a, waddr_b;
  logic [2:0]    rsrc_used;
  logic          rd_valid, is_load, alu_we, lsu_rvalid, we_a, we_b, lsu_err;
  logic [DW-1:0] alu_wdata, lsu_rdata, wdata_a, wdata_b;
  logic [NW-1:0] pending;

  logic          f_push, f_pop, f_full, f_empty;
  logic [AW-1:0] f_pdata, f_head;
  logic [1:0]    f_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_rf_writeback dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid),
    .issue_ready_o (issue_ready),
    .raddr_a_i     (raddr_a),
    .raddr_b_i     (raddr_b),
    .raddr_c_i     (raddr_c),
    .rsrc_used_i   (rsrc_used),
    .rd_i          (rd),
    .rd_valid_i    (rd_valid),
    .is_load_i     (is_load),
    .alu_we_i      (alu_we),
    .alu_waddr_i   (alu_waddr),
    .alu_wdata_i   (alu_wdata),
    .lsu_rvalid_i  (lsu_rvalid),
    .lsu_rdata_i   (lsu_rdata),
    .waddr_a_o     (waddr_a),
    .wdata_a_o     (wdata_a),
    .we_a_o        (we_a),
    .waddr_b_o     (waddr_b),
    .wdata_b_o     (wdata_b),
    .we_b_o        (we_b),
    .pending_o     (pending),
    .lsu_err_o     (lsu_err)
  );

  riscv_wb_tag_fifo #(.DEPTH(2), .WIDTH(AW), .CNT_W(2)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (f_push),
    .push_data (f_pdata),
    .pop       (f_pop),
    .head      (f_head),
    .full      (f_full),
    .empty     (f_empty),
    .count     (f_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; raddr_a = '0; raddr_b = '0; raddr_c = '0;
    rsrc_used = 3'b000; rd = '0; rd_valid = 1'b0; is_load = 1'b0;
    alu_we = 1'b0; alu_waddr = '0; alu_wdata = '0; lsu_rvalid = 1'b0; lsu_rdata = '0;
    f_push = 1'b0; f_pop = 1'b0; f_pdata = '0;

    #2;
    chk("rst_we_a", 64'(we_a), 64'd0);
    chk("rst_we_b", 64'(we_b), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_err", 64'(lsu_err), 64'd0);
    chk("rst_ready", 64'(issue_ready), 64'd1);
    #10 rst_n = 1'b1;

    // ALU write port
    alu_we = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hDEADBEEF;
    tick();
    chk("alu_we", 64'(we_a), 64'd1);
    chk("alu_waddr", 64'(waddr_a), 64'd5);
    chk("alu_wdata", 64'(wdata_a), 64'hDEADBEEF);
    alu_waddr = 5'd0; alu_wdata = 32'h12345678;
    tick();
    chk("alu_x0_we", 64'(we_a), 64'd0);
    alu_we = 1'b0;
    tick();
    chk("alu_idle_we", 64'(we_a), 64'd0);

    // Load x7 then a consumer of x7
    issue_valid = 1'b1; is_load = 1'b1; rd = 5'd7; rd_valid = 1'b1;
    #1 chk("ld7_ready", 64'(issue_ready), 64'd1);
    tick();
    chk("ld7_pending", 64'(pending), 64'h80);
    is_load = 1'b0; rsrc_used = 3'b001; raddr_a = 5'd7; rd = 5'd8;
    #1 chk("raw7_ready0", 64'(issue_ready), 64'd0);
    tick();
    chk("raw7_ready1", 64'(issue_ready), 64'd0);
    lsu_rvalid = 1'b1; lsu_rdata = 32'hCAFE0007;
    #1 chk("raw7_rsp_ready", 64'(issue_ready), 64'd0);
    tick();
    lsu_rvalid = 1'b0;
    chk("ld7_we_b", 64'(we_b), 64'd1);
    chk("ld7_waddr_b", 64'(waddr_b), 64'd7);
    chk("ld7_wdata_b", 64'(wdata_b), 64'hCAFE0007);
    #1 chk("raw7_wb_cycle_ready", 64'(issue_ready), 64'd0);
    chk("ld7_pending_wb", 64'(pending), 64'h80);
    issue_valid = 1'b0;
    tick();
    chk("ld7_we_b_off", 64'(we_b), 64'd0);
    chk("ld7_pending_clr", 64'(pending), 64'd0);
    chk("raw7_ready_after", 64'(issue_ready), 64'd1);
    chk("ld7_wdata_hold", 64'(wdata_b), 64'hCAFE0007);
    rsrc_used = 3'b000; rd_valid = 1'b0;

    // Two loads fill the FIFO, third stalls
    issue_valid = 1'b1; is_load = 1'b1; rd_valid = 1'b1; rd = 5'd3;
    #1 chk("ld3_ready", 64'(issue_ready), 64'd1);
    tick();
    rd = 5'd4;
    #1 chk("ld4_ready", 64'(issue_ready), 64'd1);
    tick();
    chk("ld34_pending", 64'(pending), 64'h18);
    rd = 5'd9;
    #1 chk("ld9_full_ready", 64'(issue_ready), 64'd0);
    lsu_rvalid = 1'b1; lsu_rdata = 32'h11;
    #1 chk("ld9_full_pop_ready", 64'(issue_ready), 64'd0);
    tick();
    chk("rsp3_we_b", 64'(we_b), 64'd1);
    chk("rsp3_waddr_b", 64'(waddr_b), 64'd3);
    chk("rsp3_wdata_b", 64'(wdata_b), 64'h11);
    chk("rsp3_pending", 64'(pending), 64'h18);
    lsu_rdata = 32'h22;
    #1 chk("ld9_ready", 64'(issue_ready), 64'd1);
    tick();
    chk("rsp4_we_b", 64'(we_b), 64'd1);
    chk("rsp4_waddr_b", 64'(waddr_b), 64'd4);
    chk("rsp4_wdata_b", 64'(wdata_b), 64'h22);
    chk("ld9_pending", 64'(pending), 64'h210);
    issue_valid = 1'b0; is_load = 1'b0; rd_valid = 1'b0; lsu_rdata = 32'h33;
    tick();
    chk("rsp9_waddr_b", 64'(waddr_b), 64'd9);
    chk("rsp9_wdata_b", 64'(wdata_b), 64'h33);
    chk("rsp9_pending", 64'(pending), 64'h200);
    lsu_rvalid = 1'b0;
    tick();
    chk("drain_we_b", 64'(we_b), 64'd0);
    chk("drain_pending", 64'(pending), 64'd0);
    chk("drain_err", 64'(lsu_err), 64'd0);

    // Load to x0 pushes a tag but never writes
    issue_valid = 1'b1; is_load = 1'b1; rd = 5'd0; rd_valid = 1'b1;
    tick();
    issue_valid = 1'b0; is_load = 1'b0; rd_valid = 1'b0;
    chk("ldx0_pending", 64'(pending), 64'd0);
    lsu_rvalid = 1'b1; lsu_rdata = 32'h44;
    tick();
    lsu_rvalid = 1'b0;
    chk("ldx0_we_b", 64'(we_b), 64'd0);
    chk("ldx0_err", 64'(lsu_err), 64'd0);
    chk("ldx0_waddr_hold", 64'(waddr_b), 64'd9);

    // Response with nothing outstanding
    lsu_rvalid = 1'b1; lsu_rdata = 32'h55;
    tick();
    lsu_rvalid = 1'b0;
    chk("orphan_we_b", 64'(we_b), 64'd0);
    chk("orphan_err", 64'(lsu_err), 64'd1);
    tick();
    chk("orphan_err_sticky", 64'(lsu_err), 64'd1);

    // Reset with a load outstanding
    issue_valid = 1'b1; is_load = 1'b1; rd = 5'd7; rd_valid = 1'b1;
    tick();
    issue_valid = 1'b0; is_load = 1'b0; rd_valid = 1'b0;
    chk("rst_ld7_pending", 64'(pending), 64'h80);
    alu_we = 1'b1; alu_waddr = 5'd6; alu_wdata = 32'hA5;
    tick();
    alu_we = 1'b0;
    chk("rst_pre_we_a", 64'(we_a), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pending", 64'(pending), 64'd0);
    chk("rst_mid_we_a", 64'(we_a), 64'd0);
    chk("rst_mid_we_b", 64'(we_b), 64'd0);
    chk("rst_mid_err", 64'(lsu_err), 64'd0);
    tick();
    rst_n = 1'b1;
    rsrc_used = 3'b001; raddr_a = 5'd7;
    #1 chk("rst_after_ready", 64'(issue_ready), 64'd1);
    rsrc_used = 3'b000;
    lsu_rvalid = 1'b1;
    tick();
    lsu_rvalid = 1'b0;
    chk("rst_late_rsp_err", 64'(lsu_err), 64'd1);
    chk("rst_late_rsp_we_b", 64'(we_b), 64'd0);

    // Tag FIFO: push and pop together while full
    f_push = 1'b1; f_pdata = 5'd1;
    tick();
    f_pdata = 5'd2;
    tick();
    chk("fifo_full_count", 64'(f_count), 64'd2);
    chk("fifo_full_flag", 64'(f_full), 64'd1);
    chk("fifo_full_head", 64'(f_head), 64'd1);
    f_pdata = 5'd3; f_pop = 1'b1;
    tick();
    chk("fifo_pp_count", 64'(f_count), 64'd2);
    chk("fifo_pp_full", 64'(f_full), 64'd1);
    chk("fifo_pp_head", 64'(f_head), 64'd2);
    f_push = 1'b0;
    tick();
    chk("fifo_pop_count", 64'(f_count), 64'd1);
    chk("fifo_pop_head", 64'(f_head), 64'd3);
    tick();
    f_pop = 1'b0;
    chk("fifo_empty", 64'(f_empty), 64'd1);
    chk("fifo_empty_count", 64'(f_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_riscv_rf_writeback
